joy_db15_tx: RTL and testbench

// - Device end of the DB15 serial joystick link: emulates the 74HC165 shift-register adapter chain.
// - Host drives JOY_LOAD/JOY_CLK; this block snapshots two 12-bit player words and returns them serially on JOY_DATA.
// - Used to drive the core's DB15 reader from another board/core, and as a bench model for that reader.

---
 rtl/joy_db15_pkg.sv | 22 ++
 rtl/joy_db15_tx_if.sv | 9 +
 rtl/joy_db15_infilt.sv | 53 +++++
 rtl/joy_db15_tx.sv | 134 +++++++++++++
 tb/tb_joy_db15_tx.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/joy_db15_pkg.sv
// Shared types and constants for the DB15 serial joystick device end.
package joy_db15_pkg;

  localparam int DB15_FRAME_BITS  = 24;
  localparam int DB15_PLAYER_BITS = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } db15_state_e;

  // Player 1 occupies the low half so it leaves the chain first.
  function automatic logic [DB15_FRAME_BITS-1:0] db15_frame(
    input logic [DB15_PLAYER_BITS-1:0] j1,
    input logic [DB15_PLAYER_BITS-1:0] j2
  );
    return {j2, j1};
  endfunction

endpackage

// File: rtl/joy_db15_tx_if.sv
// DB15 link pins between the host (reader) and the device (this shifter).
interface joy_db15_tx_if;
  logic JOY_LOAD;
  logic JOY_CLK;
  logic JOY_DATA;

  modport master (output JOY_LOAD, output JOY_CLK, input JOY_DATA);
  modport slave  (input JOY_LOAD, input JOY_CLK, output JOY_DATA);
endinterface

// File: rtl/joy_db15_infilt.sv
// Two-flop synchroniser plus stability filter for one host pin; emits
// one-cycle rise/fall strobes on the accepted level.
module joy_db15_infilt #(
  parameter int FILTER = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_rise;
  logic          r_fall;
  logic          w_differs;
  logic          w_accept;

  assign w_differs = (r_sync[1] != r_level);
  assign w_accept  = w_differs && (r_cnt == CW'(FILTER - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_rise <= w_accept &  r_sync[1];
      r_fall <= w_accept & ~r_sync[1];
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick device end: emulates the 74HC165 chain, snapshotting both
// player words on JOY_LOAD and returning them LSB-first on JOY_DATA.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int FRAME_BITS = DB15_FRAME_BITS,
  parameter int FILTER     = 3,
  parameter int TIMEOUT    = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DB15_PLAYER_BITS-1:0] joystick1,
  input  logic [DB15_PLAYER_BITS-1:0] joystick2,
  joy_db15_tx_if.slave                db15,
  output logic                        frame_done,
  output logic                        busy
);

  localparam int PW = $clog2(FRAME_BITS);
  localparam int TW = $clog2(TIMEOUT);

  logic                       w_load_rise;
  logic                       w_load_fall;
  logic                       w_clk_rise;
  logic                       w_clk_fall_unused;

  db15_state_e                r_state,  w_state_nxt;
  logic [DB15_FRAME_BITS-1:0] r_snap,   w_snap_nxt;
  logic [PW-1:0]              r_ptr,    w_ptr_nxt;
  logic [TW-1:0]              r_tmo,    w_tmo_nxt;
  logic                       r_data,   w_data_nxt;
  logic                       r_done,   w_done_nxt;
  logic [DB15_FRAME_BITS-1:0] w_live;
  logic [PW-1:0]              w_ptr_inc;

  joy_db15_infilt #(.FILTER(FILTER)) u_load_filt (
    .clk    (clk),
    .reset  (reset),
    .i_pin  (db15.JOY_LOAD),
    .o_rise (w_load_rise),
    .o_fall (w_load_fall)
  );

  joy_db15_infilt #(.FILTER(FILTER)) u_clk_filt (
    .clk    (clk),
    .reset  (reset),
    .i_pin  (db15.JOY_CLK),
    .o_rise (w_clk_rise),
    .o_fall (w_clk_fall_unused)
  );

  assign w_live    = db15_frame(joystick1, joystick2);
  assign w_ptr_inc = r_ptr + 1'b1;

  // NOTE: the snapshot is a plain register, not a RAM, so it gets a reset
  // value like every other flop and the first frame never shifts X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_ptr   <= '0;
      r_tmo   <= '0;
      r_data  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_snap  <= w_snap_nxt;
      r_ptr   <= w_ptr_nxt;
      r_tmo   <= w_tmo_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // JOY_DATA is computed from next-state values so the new bit appears one
  // cycle after the accepted strobe, not two.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_snap_nxt  = r_snap;
    w_ptr_nxt   = r_ptr;
    w_tmo_nxt   = r_tmo;
    w_data_nxt  = 1'b1;
    w_done_nxt  = 1'b0;

    if (w_load_fall) begin
      w_state_nxt = LOAD;
      w_snap_nxt  = w_live;
      w_ptr_nxt   = '0;
      w_tmo_nxt   = '0;
      w_data_nxt  = ~w_live[0];
    end else begin
      case (r_state)
        IDLE: begin
        end
        LOAD: begin
          // Parallel load overrides the shift clock, as on the 74HC165.
          w_snap_nxt = w_live;
          w_ptr_nxt  = '0;
          w_tmo_nxt  = '0;
          w_data_nxt = ~w_live[0];
          if (w_load_rise) w_state_nxt = SHIFT;
        end
        SHIFT: begin
          if (w_clk_rise) begin
            w_tmo_nxt = '0;
            if (r_ptr == PW'(FRAME_BITS - 1)) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_ptr_nxt  = w_ptr_inc;
              w_data_nxt = ~r_snap[w_ptr_inc];
            end
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            w_state_nxt = IDLE;
            w_tmo_nxt   = '0;
          end else begin
            w_tmo_nxt  = r_tmo + 1'b1;
            w_data_nxt = ~r_snap[r_ptr];
          end
        end
        DONE: begin
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign db15.JOY_DATA = r_data;
  assign frame_done    = r_done;
  assign busy          = (r_state == LOAD) || (r_state == SHIFT);

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: acts as the DB15 host and checks the
// serial frame, frame_done, busy, timeout and reset behaviour.
module tb_joy_db15_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] joystick1 = '0;
  logic [11:0] joystick2 = '0;
  logic        frame_done;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt;

  joy_db15_tx_if pins ();

  joy_db15_tx dut (
    .clk        (clk),
    .reset      (reset),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .db15       (pins),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset)           done_cnt <= 0;
    else if (frame_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_pulse(input logic [11:0] j1, input logic [11:0] j2);
    joystick1     = j1;
    joystick2     = j2;
    pins.JOY_LOAD = 1'b0;
    tick(10);
    pins.JOY_LOAD = 1'b1;
    tick(8);
  endtask

  // Host read loop: sample the current bit, then raise JOY_CLK to advance.
  task automatic shift_bits(input int rises, input bit glitch, output logic [23:0] bits);
    bits = '0;
    for (int i = 0; i < rises; i++) begin
      pins.JOY_CLK = 1'b0;
      tick(8);
      if (glitch) begin
        pins.JOY_CLK = 1'b1;
        tick(1);
        pins.JOY_CLK = 1'b0;
        tick(8);
      end
      bits[i] = ~pins.JOY_DATA;
      pins.JOY_CLK = 1'b1;
      tick(8);
    end
  endtask

  task automatic frame_end(input string tag, input logic [23:0] bits,
                           input logic [23:0] exp, input int d0);
    check({tag, "_bits"}, bits, exp);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_data_idle"}, pins.JOY_DATA, 1'b1);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    logic [23:0] bits;
    int          d0;
    int          waited;

    pins.JOY_LOAD = 1'b1;
    pins.JOY_CLK  = 1'b1;

    // Reset values, then a long idle with pins parked high.
    tick(3);
    check("rst_data", pins.JOY_DATA, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    reset = 1'b0;
    tick(10000);
    check("idle_data", pins.JOY_DATA, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_no_done", done_cnt, 0);

    // Basic frame: P1 R pressed, P2 top button pressed.
    d0 = done_cnt;
    load_pulse(12'h001, 12'h800);
    check("f1_busy_shift", busy, 1'b1);
    shift_bits(24, 1'b0, bits);
    frame_end("f1", bits, 24'h800001, d0);

    // Extra JOY_CLK rises in DONE keep the line high.
    shift_bits(2, 1'b0, bits);
    check("done_extra_clk", bits, 24'h000000);

    // Joystick change after load_rise must not reach the frame in flight.
    d0 = done_cnt;
    load_pulse(12'h0F0, 12'h000);
    joystick1 = 12'h00F;
    shift_bits(24, 1'b0, bits);
    frame_end("frozen", bits, 24'h0000F0, d0);

    // Abandoned frame: 10 rises then silence until the timeout fires.
    d0 = done_cnt;
    load_pulse(12'h123, 12'h456);
    shift_bits(10, 1'b0, bits);
    check("tmo_partial", bits, 24'h000123);
    check("tmo_busy_before", busy, 1'b1);
    waited = 0;
    while (busy && waited < 5000) begin
      tick(1);
      waited++;
    end
    check("tmo_busy_drop", busy, 1'b0);
    check("tmo_window", (waited >= 4000) && (waited <= 4200), 1'b1);
    check("tmo_no_done", done_cnt - d0, 0);
    check("tmo_data_idle", pins.JOY_DATA, 1'b1);
    d0 = done_cnt;
    load_pulse(12'h123, 12'h456);
    shift_bits(24, 1'b0, bits);
    frame_end("tmo_restart", bits, 24'h456123, d0);

    // Sub-FILTER glitches on JOY_CLK during every low phase.
    d0 = done_cnt;
    load_pulse(12'h5A5, 12'hA5A);
    shift_bits(24, 1'b1, bits);
    frame_end("glitch", bits, 24'hA5A5A5, d0);

    // JOY_LOAD held low: clock pulses ignored, data tracks ~j1[0] live.
    joystick1     = 12'h001;
    joystick2     = 12'h0C0;
    pins.JOY_LOAD = 1'b0;
    tick(10);
    check("hold_busy", busy, 1'b1);
    check("hold_data0", pins.JOY_DATA, 1'b0);
    repeat (3) begin
      pins.JOY_CLK = 1'b0;
      tick(8);
      pins.JOY_CLK = 1'b1;
      tick(8);
    end
    check("hold_clk_ignored", pins.JOY_DATA, 1'b0);
    joystick1 = 12'h000;
    tick(2);
    check("hold_live_hi", pins.JOY_DATA, 1'b1);
    joystick1 = 12'h001;
    tick(2);
    check("hold_live_lo", pins.JOY_DATA, 1'b0);
    d0 = done_cnt;
    pins.JOY_LOAD = 1'b1;
    tick(8);
    shift_bits(24, 1'b0, bits);
    frame_end("hold", bits, 24'h0C0001, d0);

    // Reset mid-frame while bit 13 (P2 L, pressed) is on the line.
    load_pulse(12'h3C5, 12'h002);
    shift_bits(13, 1'b0, bits);
    check("mid_partial", bits, 24'h0003C5);
    check("mid_bit13_low", pins.JOY_DATA, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_data", pins.JOY_DATA, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    tick(3);
    reset = 1'b0;
    tick(5);
    d0 = done_cnt;
    load_pulse(12'h3C5, 12'h002);
    shift_bits(24, 1'b0, bits);
    frame_end("post_rst", bits, 24'h0023C5, d0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
